multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/writeback and drives the mux selects and write strobes.
- Generates the 3-bit ALU operation code and the shift-type bit consumed by the existing ALU, i.e. it is the producer side of the ALU control interface.
- Sits between the instruction register (op/funct fields) and the datapath; uses the ALU zero flag to resolve branches.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction/OldPC register enable
- result_src  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- reg_write  out  1  register file write strobe
- alu_ctrl  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL/SRA
- alu_op7b5  out  1  shift type to ALU: 1 = SRA, 0 = SRL
- illegal  out  1  unsupported opcode seen in DECODE
- state  out  STATE_W  current state (debug)

Behaviour:
- Reset and clocking:
  - Single clock. Reset is synchronous and active-low: rst_n sampled low at a rising edge forces state = FETCH.
  - While rst_n = 0, pc_write, ir_write, mem_write, reg_write and illegal are forced to 0 combinationally. Other outputs take their FETCH values.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10. Codes 11-15 are unreachable and go to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JAL; any other op -> FETCH with illegal = 1 for that DECODE cycle only.
  - MEMADR -> MEMREAD if op = 0000011, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH. MEMWRITE -> FETCH.
  - EXECUTER -> ALUWB. EXECUTEI -> ALUWB. JAL -> ALUWB. ALUWB -> FETCH. BRANCH -> FETCH.
- Per-state outputs (Moore; anything unlisted is 0):
  - FETCH: ir_write = 1, adr_src = 0, a = 00, b = 10, aluop = ADD, result_src = 10, pc_update = 1.
  - DECODE: a = 01, b = 01, aluop = ADD (branch target into ALUOut).
  - MEMADR: a = 10, b = 01, aluop = ADD.
  - MEMREAD: adr_src = 1, result_src = 00.
  - MEMWB: result_src = 01, reg_write = 1.
  - MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1.
  - EXECUTER: a = 10, b = 00, aluop = FUNCT.
  - EXECUTEI: a = 10, b = 01, aluop = FUNCT.
  - ALUWB: result_src = 00, reg_write = 1.
  - BRANCH: a = 10, b = 00, aluop = SUB, result_src = 00, branch = 1.
  - JAL: a = 01, b = 10, aluop = ADD, result_src = 00, pc_update = 1.
- pc_write = pc_update | (branch & (zero ^ funct3[0])). This gives BEQ (funct3 000) and BNE (funct3 001). Combinational, same cycle as zero.
- imm_src is combinational from op: load/OP-IMM -> 00, store -> 01, branch -> 10, jal -> 11, other -> 00.
- ALU decode when aluop = FUNCT, by funct3:
  - 000: SUB if (funct7b5 & op[5]) else ADD. OP-IMM is always ADD.
  - 001 -> SLL; 010 -> SLT; 100 -> XOR; 101 -> 111; 110 -> OR; 111 -> AND.
  - 011 (SLTU, unsupported) -> ADD.
- alu_op7b5 = funct7b5 only when aluop = FUNCT and funct3 = 101; otherwise 0.
- Instruction latency in cycles: lw 5, sw 4, R/I 4, branch 3, jal 4.
- Reset mid-instruction: the next rising edge with rst_n low aborts to FETCH. A strobe already asserted drops in the same cycle rst_n falls.

Test Plan:
- add x3,x1,x2 (0x002081B3): rst_n = 0 for 2 edges, then 1 -> states 0,1,6,8,0; alu_ctrl = 000 in EXECUTER; reg_write = 1 only in ALUWB; ir_write = 1 and pc_write = 1 only in FETCH.
- sub (op 0110011, funct3 000, funct7b5 1) -> alu_ctrl = 001 in EXECUTER. addi with funct7b5 = 1 -> alu_ctrl = 000 in EXECUTEI.
- srai (op 0010011, funct3 101, funct7b5 1) -> alu_ctrl = 111, alu_op7b5 = 1. srli (funct7b5 0) -> alu_op7b5 = 0. In FETCH alu_ctrl = 000 and alu_op7b5 = 0.
- beq (funct3 000) with zero = 1 -> pc_write = 1 in BRANCH, alu_ctrl = 001. With zero = 0 -> pc_write = 0. bne (funct3 001) with zero = 1 -> pc_write = 0.
- lw: states 0,1,2,3,4, with adr_src = 1 in MEMREAD and result_src = 01 with reg_write in MEMWB. sw: states 0,1,2,5, with mem_write = 1 only in MEMWRITE, imm_src = 01.
- op = 0000000 -> illegal = 1 for one cycle in DECODE, next state FETCH. rst_n = 0 during MEMWRITE -> mem_write = 0 immediately and state = 0 after the edge. Force state = 13 -> next state 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath. Sequences fetch, decode,
// execute and writeback, drives the datapath mux selects and write strobes,
// and produces the ALU operation code plus the shift-type bit for the ALU.
module multicycle_ctrl #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic               reg_write,
    output logic [2:0]         alu_ctrl,
    output logic               alu_op7b5,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    // Opcodes handled by this controller.
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // ALU operation codes as seen by the ALU.
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [2:0] AluSll = 3'b110;
    localparam logic [2:0] AluSrx = 3'b111;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10
    } state_e;

    // Coarse ALU request from the FSM; AopFunct defers to the funct fields.
    typedef enum logic [1:0] {
        AopAdd   = 2'b00,
        AopSub   = 2'b01,
        AopFunct = 2'b10
    } aluop_e;

    state_e       r_state;
    state_e       w_state_d;
    state_e       w_out_state;
    aluop_e       w_aluop;
    logic         w_illegal_op;
    logic         w_pc_update;
    logic         w_branch;
    logic         w_ir_write;
    logic         w_mem_write;
    logic         w_reg_write;
    logic         w_adr_src;
    logic [1:0]   w_result_src;
    logic [1:0]   w_alu_src_a;
    logic [1:0]   w_alu_src_b;
    logic         w_take_branch;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Opcode legality as seen from DECODE.
    always_comb begin
        w_illegal_op = 1'b0;
        case (op)
            OpLoad, OpStore, OpReg, OpImm, OpBranch, OpJal: w_illegal_op = 1'b0;
            default:                                        w_illegal_op = 1'b1;
        endcase
    end

    // Next-state logic; unreachable encodings fall back to FETCH.
    always_comb begin
        w_state_d = StFetch;
        case (r_state)
            StFetch: w_state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: w_state_d = StMemAdr;
                    OpReg:           w_state_d = StExecuteR;
                    OpImm:           w_state_d = StExecuteI;
                    OpBranch:        w_state_d = StBranch;
                    OpJal:           w_state_d = StJal;
                    default:         w_state_d = StFetch;
                endcase
            end
            StMemAdr:   w_state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  w_state_d = StMemWb;
            StMemWb:    w_state_d = StFetch;
            StMemWrite: w_state_d = StFetch;
            StExecuteR: w_state_d = StAluWb;
            StExecuteI: w_state_d = StAluWb;
            StJal:      w_state_d = StAluWb;
            StAluWb:    w_state_d = StFetch;
            StBranch:   w_state_d = StFetch;
            default:    w_state_d = StFetch;
        endcase
    end

    // While reset is held the outputs show FETCH values even mid-instruction.
    assign w_out_state = rst_n ? r_state : StFetch;

    // Moore outputs decoded from the (reset-adjusted) current state.
    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_aluop      = AopAdd;
        case (w_out_state)
            StFetch: begin
                w_ir_write   = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_update  = 1'b1;
            end
            StDecode: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            StMemAdr: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            StMemRead: begin
                w_adr_src = 1'b1;
            end
            StMemWb: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            StMemWrite: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            StExecuteR: begin
                w_alu_src_a = 2'b10;
                w_aluop     = AopFunct;
            end
            StExecuteI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_aluop     = AopFunct;
            end
            StAluWb: begin
                w_reg_write = 1'b1;
            end
            StBranch: begin
                w_alu_src_a = 2'b10;
                w_aluop     = AopSub;
                w_branch    = 1'b1;
            end
            StJal: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_update = 1'b1;
            end
            default: begin
                w_aluop = AopAdd;
            end
        endcase
    end

    // funct3[0] selects BNE (taken on non-zero) versus BEQ (taken on zero).
    assign w_take_branch = w_branch & (zero ^ funct3[0]);

    // ALU control: direct ops from the FSM, or decode of funct3/funct7b5.
    always_comb begin
        alu_ctrl  = AluAdd;
        alu_op7b5 = 1'b0;
        case (w_aluop)
            AopAdd: alu_ctrl = AluAdd;
            AopSub: alu_ctrl = AluSub;
            AopFunct: begin
                case (funct3)
                    3'b000:  alu_ctrl = (funct7b5 & op[5]) ? AluSub : AluAdd;
                    3'b001:  alu_ctrl = AluSll;
                    3'b010:  alu_ctrl = AluSlt;
                    3'b011:  alu_ctrl = AluAdd;
                    3'b100:  alu_ctrl = AluXor;
                    3'b101: begin
                        alu_ctrl  = AluSrx;
                        alu_op7b5 = funct7b5;
                    end
                    3'b110:  alu_ctrl = AluOr;
                    3'b111:  alu_ctrl = AluAnd;
                    default: alu_ctrl = AluAdd;
                endcase
            end
            default: alu_ctrl = AluAdd;
        endcase
    end

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OpStore:  imm_src = 2'b01;
            OpBranch: imm_src = 2'b10;
            OpJal:    imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    // Strobes are gated by rst_n so they drop in the same cycle reset asserts.
    assign pc_write   = rst_n & (w_pc_update | w_take_branch);
    assign ir_write   = rst_n & w_ir_write;
    assign mem_write  = rst_n & w_mem_write;
    assign reg_write  = rst_n & w_reg_write;
    assign illegal    = rst_n & (r_state == StDecode) & w_illegal_op;
    assign adr_src    = w_adr_src;
    assign result_src = w_result_src;
    assign alu_src_a  = w_alu_src_a;
    assign alu_src_b  = w_alu_src_b;
    assign state      = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions followed by
// randomized instruction streams, checked against a behavioural model.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [2:0] alu_ctrl;
    logic       alu_op7b5;
    logic       illegal;
    logic [3:0] state;

    int total;
    int bad;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .alu_ctrl   (alu_ctrl),
        .alu_op7b5  (alu_op7b5),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    // Observed outputs packed in the same order as the model vector.
    logic [17:0] dut_vec;
    assign dut_vec = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                      alu_src_b, reg_write, alu_ctrl, alu_op7b5, illegal, imm_src};

    function automatic logic is_legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR) || (o == JL);
    endfunction

    // ALU code chosen by instruction meaning for R/I-type arithmetic.
    function automatic logic [2:0] arith_alu(input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7);
        case (f3)
            3'd0:    return (o == RT && f7) ? 3'b001 : 3'b000;  // sub vs add/addi
            3'd1:    return 3'b110;                              // sll
            3'd2:    return 3'b101;                              // slt
            3'd3:    return 3'b000;                              // sltu unsupported
            3'd4:    return 3'b100;                              // xor
            3'd5:    return 3'b111;                              // srl/sra
            3'd6:    return 3'b011;                              // or
            default: return 3'b010;                              // and
        endcase
    endfunction

    // Expected output vector for a given step (named by state code) of an instruction.
    function automatic logic [17:0] model(input int s, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic rn);
        logic       pcw, adr, mw, irw, rw, sh, ill;
        logic [1:0] rs, a, b, imm;
        logic [2:0] alu;
        int         se;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; sh = 0; ill = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
        se = rn ? s : 0;
        case (se)
            0:  begin irw = 1; b = 2'b10; rs = 2'b10; pcw = 1; end
            1:  begin a = 2'b01; b = 2'b01; ill = !is_legal(o); end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin a = 2'b10; alu = arith_alu(o, f3, f7); sh = (f3 == 3'd5) && f7; end
            7:  begin a = 2'b10; b = 2'b01; alu = arith_alu(o, f3, f7); sh = (f3 == 3'd5) && f7; end
            8:  rw = 1;
            9:  begin a = 2'b10; alu = 3'b001; pcw = f3[0] ? !z : z; end
            10: begin a = 2'b01; b = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (!rn) begin
            pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0;
        end
        case (o)
            SW:      imm = 2'b01;
            BR:      imm = 2'b10;
            JL:      imm = 2'b11;
            default: imm = 2'b00;
        endcase
        return {pcw, adr, mw, irw, rs, a, b, rw, alu, sh, ill, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH; zmode < 0 randomizes zero.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int zmode);
        int seq[$];
        case (o)
            LW:      seq = '{0, 1, 2, 3, 4};
            SW:      seq = '{0, 1, 2, 5};
            RT:      seq = '{0, 1, 6, 8};
            IT:      seq = '{0, 1, 7, 8};
            BR:      seq = '{0, 1, 9};
            JL:      seq = '{0, 1, 10, 8};
            default: seq = '{0, 1};
        endcase
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        foreach (seq[i]) begin
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            chk($sformatf("%s state[%0d]", tag, i), 32'(state), 32'(seq[i]));
            chk($sformatf("%s outs[%0d]", tag, i), 32'(dut_vec),
                32'(model(seq[i], o, f3, f7, zero, 1'b1)));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] rop;
        int         k;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        op = RT; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;

        // Reset held for two edges: strobes low immediately, then FETCH.
        #1;
        chk("reset strobes", 32'({pc_write, ir_write, mem_write, reg_write, illegal}), 32'd0);
        @(posedge clk); #1;
        chk("reset state1", 32'(state), 32'd0);
        @(posedge clk); #1;
        chk("reset state2", 32'(state), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post reset outs", 32'(dut_vec), 32'(model(0, RT, 3'b000, 1'b0, 1'b0, 1'b1)));

        // Directed instructions.
        run_instr("add",    RT, 3'b000, 1'b0, 0);
        run_instr("sub",    RT, 3'b000, 1'b1, 0);
        run_instr("addi7",  IT, 3'b000, 1'b1, 0);
        run_instr("srai",   IT, 3'b101, 1'b1, 0);
        run_instr("srli",   IT, 3'b101, 1'b0, 0);
        run_instr("sra",    RT, 3'b101, 1'b1, 0);
        run_instr("beq_t",  BR, 3'b000, 1'b0, 1);
        run_instr("beq_nt", BR, 3'b000, 1'b0, 0);
        run_instr("bne_nt", BR, 3'b001, 1'b0, 1);
        run_instr("bne_t",  BR, 3'b001, 1'b0, 0);
        run_instr("lw",     LW, 3'b010, 1'b0, 0);
        run_instr("sw",     SW, 3'b010, 1'b0, 0);
        run_instr("jal",    JL, 3'b000, 1'b0, 0);
        run_instr("ill0",   7'b0000000, 3'b000, 1'b0, 0);
        chk("after illegal state", 32'(state), 32'd0);

        // Reset asserted while in MEMWRITE.
        op = SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("mw state", 32'(state), 32'd5);
        chk("mw strobe", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst mid outs", 32'(dut_vec), 32'(model(5, SW, 3'b010, 1'b0, 1'b0, 1'b0)));
        chk("rst mid mem_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        chk("rst mid state", 32'(state), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst mid fetch", 32'(dut_vec), 32'(model(0, SW, 3'b010, 1'b0, 1'b0, 1'b1)));
        @(posedge clk); #1;
        chk("rst mid decode", 32'(state), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst mid resync", 32'(state), 32'd0);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 7));
            case (k)
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = IT;
                4: rop = BR;
                5: rop = JL;
                default: begin
                    rop = 7'($urandom);
                    while (is_legal(rop)) rop = 7'($urandom);
                end
            endcase
            run_instr($sformatf("rnd%0d", n), rop, 3'($urandom), 1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
